shift_out_scheduler: RTL and testbench

//   Sequences and shares the 7-segment serial shifter (output_wrapper) between

---
 rtl/shift_out_scheduler_pkg.sv | 33 +++
 rtl/shift_out_scheduler_timer.sv | 45 ++++
 rtl/shift_out_scheduler.sv | 162 ++++++++++++++++
 tb/tb_shift_out_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_out_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_out_scheduler_pkg
// Brief    : Shared state encoding and default timing constants for the
//            7-segment shift-out scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package shift_out_scheduler_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_GAP     = 3'd4
  } sched_state_t;

  // Default timing constants
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_BUSY_TIMEOUT  = 64;
  localparam int DEF_MIN_GAP       = 16;
  localparam int DEF_OVR_W         = 8;

  // Largest of three timer reload values, used to size the shared timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_out_scheduler_timer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_timer
// Brief    : Loadable down-counter. o_done is high during the last counted
//            cycle (count of 1) so a state lasts exactly the loaded length.
//            Stops at zero, never wraps.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_timer #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload has priority; otherwise count down while enabled, holding at zero
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = i_en && (cnt_q <= W'(1));

endmodule
`default_nettype wire

// File: rtl/shift_out_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : shift_out_scheduler
// Brief    : Shares the serial 7-segment shifter between update, blink and
//            refresh requesters. Coalesces pending requests, waits a settle
//            delay, handshakes on shifter busy with timeouts, then enforces
//            an idle gap before the next transfer.
// Revision : 1.0 - initial release
// ============================================================================
module shift_out_scheduler
  import shift_out_scheduler_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int BUSY_TIMEOUT  = DEF_BUSY_TIMEOUT,
  parameter int MIN_GAP       = DEF_MIN_GAP,
  parameter int OVR_W         = DEF_OVR_W
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_update_stb,
  input  logic             i_blink_stb,
  input  logic             i_refresh_stb,
  input  logic             i_busy,
  output logic             o_start_stb,
  output logic             o_colon,
  output logic             o_active,
  output logic             o_timeout,
  output logic [OVR_W-1:0] o_overrun
);

  localparam int TMR_W = $clog2(max3(SETTLE_CYCLES, BUSY_TIMEOUT, MIN_GAP)) + 1;
  localparam logic [OVR_W-1:0] C_OVR_MAX = {OVR_W{1'b1}};

  sched_state_t     state_q, state_d;
  logic             upd_q, upd_d, blk_q, blk_d, ref_q, ref_d;
  logic             start_q, start_d;
  logic             colon_q, colon_d;
  logic             active_q, active_d;
  logic             timeout_q, timeout_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  logic             w_any_req;
  logic             w_accept;
  logic [1:0]       w_ovr_inc;
  logic [OVR_W+1:0] w_ovr_sum;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_done;

  // A request may be accepted in the very cycle its strobe arrives
  assign w_any_req = upd_q | blk_q | ref_q | i_update_stb | i_blink_stb | i_refresh_stb;
  assign w_accept  = (state_q == ST_IDLE) && i_en && w_any_req;

  // Pending flags, colon toggle and saturating overrun count
  always_comb begin
    upd_d     = w_accept ? 1'b0 : (upd_q | i_update_stb);
    blk_d     = w_accept ? 1'b0 : (blk_q | i_blink_stb);
    ref_d     = w_accept ? 1'b0 : (ref_q | i_refresh_stb);
    colon_d   = colon_q ^ i_blink_stb;
    w_ovr_inc = {1'b0, i_update_stb & upd_q} + {1'b0, i_blink_stb & blk_q}
              + {1'b0, i_refresh_stb & ref_q};
    w_ovr_sum = {2'b00, ovr_q} + {{OVR_W{1'b0}}, w_ovr_inc};
    ovr_d     = (w_ovr_sum > {2'b00, C_OVR_MAX}) ? C_OVR_MAX : w_ovr_sum[OVR_W-1:0];
  end

  // Next state, start pulse, sticky timeout and timer reload selection
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_tmr_done) begin
          state_d = ST_WAIT_HI;
          start_d = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (i_busy) begin
          state_d = ST_WAIT_LO;
        end else if (w_tmr_done) begin
          timeout_d = 1'b1;
          state_d   = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_WAIT_LO: begin
        if (!i_busy) begin
          state_d = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
        end else if (w_tmr_done) begin
          timeout_d = 1'b1;
          state_d   = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d == ST_SETTLE) || (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO);

    // The single timer is reloaded on every state entry with that state's length
    w_tmr_load = (state_d != state_q);
    w_tmr_en   = (state_q != ST_IDLE);
    case (state_d)
      ST_SETTLE:  w_tmr_val = TMR_W'(SETTLE_CYCLES);
      ST_WAIT_HI: w_tmr_val = TMR_W'(BUSY_TIMEOUT);
      ST_WAIT_LO: w_tmr_val = TMR_W'(BUSY_TIMEOUT);
      ST_GAP:     w_tmr_val = TMR_W'(MIN_GAP);
      default:    w_tmr_val = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      upd_q     <= 1'b0;
      blk_q     <= 1'b0;
      ref_q     <= 1'b0;
      start_q   <= 1'b0;
      colon_q   <= 1'b0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      upd_q     <= upd_d;
      blk_q     <= blk_d;
      ref_q     <= ref_d;
      start_q   <= start_d;
      colon_q   <= colon_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
      ovr_q     <= ovr_d;
    end
  end

  cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_done     (w_tmr_done)
  );

  assign o_start_stb = start_q;
  assign o_colon     = colon_q;
  assign o_active    = active_q;
  assign o_timeout   = timeout_q;
  assign o_overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_out_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_out_scheduler
// Brief    : Directed self-checking bench for shift_out_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_out_scheduler;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_en = 1'b0;
  logic       i_update_stb = 1'b0;
  logic       i_blink_stb = 1'b0;
  logic       i_refresh_stb = 1'b0;
  logic       i_busy = 1'b0;
  logic       o_start_stb;
  logic       o_colon;
  logic       o_active;
  logic       o_timeout;
  logic [7:0] o_overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0;
  int s_cyc;
  int s0;

  shift_out_scheduler dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_en          (i_en),
    .i_update_stb  (i_update_stb),
    .i_blink_stb   (i_blink_stb),
    .i_refresh_stb (i_refresh_stb),
    .i_busy        (i_busy),
    .o_start_stb   (o_start_stb),
    .o_colon       (o_colon),
    .o_active      (o_active),
    .o_timeout     (o_timeout),
    .o_overrun     (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Cycle index: value k during the cycle following the k-th rising edge
  always @(posedge i_clk) cyc <= cyc + 1;

  // Count start pulses away from the active edge
  always @(negedge i_clk) if (o_start_stb === 1'b1) start_cnt++;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_upd();
    i_update_stb = 1'b1;
    tick();
    i_update_stb = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (o_start_stb !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("start_seen", int'(o_start_stb), 1);
  endtask

  // Complete a transfer with a short busy pulse, then let the gap expire
  task automatic do_xfer();
    wait_start(20);
    tick();
    i_busy = 1'b1;
    tick();
    i_busy = 1'b0;
    repeat (20) tick();
  endtask

  initial begin
    // ---- reset state
    i_reset_n = 1'b0;
    repeat (3) tick();
    i_reset_n = 1'b1;
    chk("rst_start",   int'(o_start_stb), 0);
    chk("rst_colon",   int'(o_colon), 0);
    chk("rst_active",  int'(o_active), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    tick();

    // ---- 1: single update, start at t0+5, active falls after busy, gap 16
    i_en = 1'b1;
    s0 = start_cnt;
    pulse_upd();
    chk("t1_active_on", int'(o_active), 1);
    repeat (3) tick();
    chk("t1_no_early_start", int'(o_start_stb), 0);
    tick();
    chk("t1_start_t0p5", int'(o_start_stb), 1);
    s_cyc = cyc;
    repeat (3) tick();
    i_busy = 1'b1;
    repeat (20) tick();
    i_busy = 1'b0;
    chk("t1_active_while_busy", int'(o_active), 1);
    tick();
    chk("t1_active_off", int'(o_active), 0);
    pulse_upd();
    begin
      int n = 0;
      while (o_active !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
    end
    chk("t1_next_accept_cycle", cyc, s_cyc + 41);
    do_xfer();
    chk("t1_start_count", start_cnt - s0, 2);

    // ---- 2: three strobes same cycle -> one transfer, colon on, no overrun
    s0 = start_cnt;
    i_update_stb = 1'b1;
    i_blink_stb = 1'b1;
    i_refresh_stb = 1'b1;
    tick();
    i_update_stb = 1'b0;
    i_blink_stb = 1'b0;
    i_refresh_stb = 1'b0;
    do_xfer();
    repeat (10) tick();
    chk("t2_one_start", start_cnt - s0, 1);
    chk("t2_colon", int'(o_colon), 1);
    chk("t2_overrun", int'(o_overrun), 0);

    // ---- 3: held off, two updates -> overrun 1, single transfer on enable
    i_en = 1'b0;
    s0 = start_cnt;
    pulse_upd();
    tick();
    pulse_upd();
    chk("t3_overrun", int'(o_overrun), 1);
    repeat (5) tick();
    chk("t3_held", int'(o_active), 0);
    i_en = 1'b1;
    do_xfer();
    repeat (30) tick();
    chk("t3_one_start", start_cnt - s0, 1);

    // ---- 4: update during WAIT_LO -> exactly one more start after the gap
    s0 = start_cnt;
    pulse_upd();
    wait_start(20);
    s_cyc = cyc;
    tick();
    i_busy = 1'b1;
    tick();
    pulse_upd();
    repeat (5) tick();
    i_busy = 1'b0;
    wait_start(40);
    chk("t4_second_start_cycle", cyc, s_cyc + 30);
    tick();
    i_busy = 1'b1;
    tick();
    i_busy = 1'b0;
    repeat (60) tick();
    chk("t4_two_starts", start_cnt - s0, 2);

    // ---- 5: busy never rises -> timeout 64 cycles after start
    pulse_upd();
    wait_start(20);
    repeat (63) tick();
    chk("t5_timeout_not_yet", int'(o_timeout), 0);
    tick();
    chk("t5_timeout_set", int'(o_timeout), 1);
    chk("t5_active_off", int'(o_active), 0);
    repeat (20) tick();
    s0 = start_cnt;
    pulse_upd();
    do_xfer();
    chk("t5_serviced", start_cnt - s0, 1);
    chk("t5_timeout_sticky", int'(o_timeout), 1);

    // ---- 6: reset during SETTLE aborts; blink flood saturates overrun
    s0 = start_cnt;
    pulse_upd();
    tick();
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    chk("t6_rst_active",  int'(o_active), 0);
    chk("t6_rst_timeout", int'(o_timeout), 0);
    chk("t6_rst_colon",   int'(o_colon), 0);
    chk("t6_rst_overrun", int'(o_overrun), 0);
    chk("t6_rst_start",   int'(o_start_stb), 0);
    repeat (20) tick();
    chk("t6_no_start_after_rst", start_cnt - s0, 0);
    i_en = 1'b0;
    i_blink_stb = 1'b1;
    repeat (300) tick();
    i_blink_stb = 1'b0;
    tick();
    chk("t6_overrun_sat", int'(o_overrun), 255);
    chk("t6_colon_even", int'(o_colon), 0);
    chk("t6_held_idle", int'(o_active), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
